seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Serial bit-pattern transmitter that drives the single-bit input stream `w` consumed by the FSM sequence detectors (`seq_det_*`). It loads a programmable pattern of up to 8 bits on a start handshake, shifts it out MSB-first one bit per clock, repeats it a programmed number of times with optional idle gaps, and reports completion. It is the stimulus/producer end of the detector's `w` interface, usable in self-checking benches and as an on-chip pattern source.

## Interface

Parameters:
- `GAP_CYC`, default 2: idle cycles (w=0, w_valid=0) inserted between repetitions; legal range 0..15.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request to begin a transfer; sampled only in IDLE
- `pattern`  in  8  bit pattern; bit `len-1` is sent first, bit 0 last
- `len`  in  4  pattern length in bits, 1..8; 0 or >8 makes `start` ignored
- `reps`  in  4  repetition count; 1..15 = that many, 0 = continuous until `abort`
- `abort`  in  1  terminate the transfer immediately, no `done`
- `w`  out  1  serial data bit to the detector
- `w_valid`  out  1  high while `w` carries a pattern bit
- `busy`  out  1  high from first bit through last bit, including gaps
- `done`  out  1  one-cycle pulse after the final bit of the final repetition

## Operation

- States: IDLE, SEND, GAP, DONE.
- IDLE: w=0, w_valid=0, busy=0. On `start`=1 with 1<=len<=8: latch `pattern`, `len`, `reps` into internal registers; load the bit index with len-1 and the repetition counter with `reps`; go to SEND.
- SEND: w = latched_pattern[idx], w_valid=1, busy=1; decrement idx each cycle. At idx=0 (last bit):
  - if reps_latched=0 (continuous) or remaining reps>1: decrement remaining (not in continuous mode); reload idx=len-1; go to GAP if GAP_CYC>0, else stay in SEND (back-to-back, no bubble).
  - else go to DONE.
- GAP: w=0, w_valid=0, busy=1 for exactly GAP_CYC cycles, then SEND.
- DONE: done=1, busy=0, w=0, w_valid=0 for one cycle, then IDLE.
- `start` outside IDLE is ignored; input changes on `pattern`/`len`/`reps` after latching have no effect.
- `abort`=1 in SEND or GAP: next cycle IDLE, w=0, w_valid=0, busy=0, done never pulses. `abort` in IDLE/DONE has no effect. `abort` and `start` together in IDLE: `abort` wins, no transfer.
- `rst` overrides everything, including `start` and `abort` in the same cycle.
- Counters: 3-bit bit index, 4-bit repetition counter, 4-bit gap counter; no wrap-around is ever reachable in finite mode.

## Timing

- All outputs registered; reset values: w=0, w_valid=0, busy=0, done=0, state=IDLE.
- `start` sampled at edge k → first bit on `w` during cycle k+1 (1-cycle latency).
- One bit per clock; a finite transfer occupies reps*len + (reps-1)*GAP_CYC cycles with busy=1, then `done` in the following cycle.
- Earliest next `start` accepted: the cycle `done` is high is DONE, so `start` is sampled in the first IDLE cycle after `done`.
- `abort` sampled at edge k → outputs idle from cycle k+1.

## Test plan

- Reset, then start at cycle 0 with pattern=8'h0B, len=4, reps=1 → w=1,0,1,1 on cycles 1–4, w_valid=1 and busy=1 on cycles 1–4, done=1 on cycle 5 only, w=0 after.
- pattern=8'b101, len=3, reps=2, GAP_CYC=2 → w=1,0,1,0,0,1,0,1 on cycles 1–8 with w_valid=1,1,1,0,0,1,1,1; done on cycle 9.
- GAP_CYC=0, pattern=8'b11, len=2, reps=3 → w=1 for 6 consecutive cycles with w_valid continuously high; done on cycle 7.
- reps=0, pattern=8'b10, len=2, GAP_CYC=0; abort at cycle 9 → w alternates 1,0 from cycle 1 through cycle 9; cycle 10 onward w=0, busy=0, done never asserted.
- len=0 or len=9 with start → no state change, all outputs stay 0; start pulsed again during busy → ignored, original sequence unaffected.
- rst asserted mid-SEND (cycle 3 of an 8-bit transfer) → from next cycle all outputs 0, IDLE; a new start afterwards produces a full, correct sequence.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: MSB-first serial pattern source with repeats and idle gaps
module seq_pattern_gen #(
  parameter int GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [3:0] len,
  input  logic [3:0] reps,
  input  logic       abort,
  output logic       w,
  output logic       w_valid,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  localparam logic [3:0] GAP_LD = 4'(GAP_CYC - 1);
  state_t     state;
  logic [7:0] pat;
  logic [2:0] idx, top, len_top;
  logic [3:0] rem, gcnt;
  logic       more;
  // rem==0 only ever occurs in continuous mode; finite mode stops decrementing at 1
  assign more    = rem == 4'd0 || rem > 4'd1;
  assign len_top = len[2:0] - 3'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pat     <= '0;
      idx     <= '0;
      top     <= '0;
      rem     <= '0;
      gcnt    <= '0;
      w       <= 1'b0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort && (state == SEND || state == GAP)) begin
      state   <= IDLE;
      w       <= 1'b0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !abort && len != 4'd0 && len <= 4'd8) begin
          pat     <= pattern;
          top     <= len_top;
          idx     <= len_top;
          rem     <= reps;
          state   <= SEND;
          w       <= pattern[len_top];
          w_valid <= 1'b1;
          busy    <= 1'b1;
        end
        SEND: if (idx != 3'd0) begin
          idx <= idx - 3'd1;
          w   <= pat[idx - 3'd1];
        end else if (more) begin
          if (rem != 4'd0) rem <= rem - 4'd1;
          idx <= top;
          if (GAP_CYC > 0) begin
            state   <= GAP;
            gcnt    <= GAP_LD;
            w       <= 1'b0;
            w_valid <= 1'b0;
          end else w <= pat[top];
        end else begin
          state   <= DONE;
          w       <= 1'b0;
          w_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        GAP: if (gcnt == 4'd0) begin
          state   <= SEND;
          w       <= pat[idx];
          w_valid <= 1'b1;
        end else gcnt <= gcnt - 4'd1;
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed checks of seq_pattern_gen with gap 2 and gap 0 instances
module tb_seq_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       w2, v2, b2, d2, w0, v0, b0, d0;
  logic [31:0] cw, cv, cb, cd;
  int total = 0;
  int bad = 0;

  seq_pattern_gen #(.GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .w(w2), .w_valid(v2), .busy(b2), .done(d2)
  );
  seq_pattern_gen #(.GAP_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .w(w0), .w_valid(v0), .busy(b0), .done(d0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a transfer and records n cycles (cycle 1 first, MSB-first in the vectors).
  // kind: 0 abort, 1 start pulse with different inputs, 2 rst -- applied during cycle ev.
  task automatic tx(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                    input logic a0, input int n, input int sel, input int ev, input int kind);
    pattern = p; len = l; reps = r; start = 1'b1; abort = a0;
    cw = '0; cv = '0; cb = '0; cd = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cw = {cw[30:0], sel != 0 ? w0 : w2};
      cv = {cv[30:0], sel != 0 ? v0 : v2};
      cb = {cb[30:0], sel != 0 ? b0 : b2};
      cd = {cd[30:0], sel != 0 ? d0 : d2};
      start = kind == 1 && i == ev;
      abort = kind == 0 && i == ev;
      rst   = kind == 2 && i == ev;
      if (start) begin
        pattern = 8'hFF;
        len = 4'd8;
        reps = 4'd3;
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {28'd0, w2, v2, b2, d2}, 32'd0);
    rst = 1'b0;

    tx(8'h0B, 4'd4, 4'd1, 1'b0, 6, 0, 0, 0);
    chk("t1_w", cw, 32'b101100);
    chk("t1_valid", cv, 32'b111100);
    chk("t1_busy", cb, 32'b111100);
    chk("t1_done", cd, 32'b000010);

    do_rst();
    tx(8'b101, 4'd3, 4'd2, 1'b0, 10, 0, 0, 0);
    chk("t2_w", cw, 32'b1010010100);
    chk("t2_valid", cv, 32'b1110011100);
    chk("t2_busy", cb, 32'b1111111100);
    chk("t2_done", cd, 32'b0000000010);

    do_rst();
    tx(8'b11, 4'd2, 4'd3, 1'b0, 8, 1, 0, 0);
    chk("t3_w", cw, 32'b11111100);
    chk("t3_valid", cv, 32'b11111100);
    chk("t3_busy", cb, 32'b11111100);
    chk("t3_done", cd, 32'b00000010);

    do_rst();
    tx(8'b10, 4'd2, 4'd0, 1'b0, 12, 1, 9, 0);
    chk("t4_w", cw, 32'b101010101000);
    chk("t4_valid", cv, 32'b111111111000);
    chk("t4_busy", cb, 32'b111111111000);
    chk("t4_done", cd, 32'b0);

    do_rst();
    tx(8'hFF, 4'd0, 4'd1, 1'b0, 3, 0, 0, 0);
    chk("len0", cw | cv | cb | cd, 32'b0);
    tx(8'hFF, 4'd9, 4'd1, 1'b0, 3, 0, 0, 0);
    chk("len9", cw | cv | cb | cd, 32'b0);
    tx(8'hFF, 4'd4, 4'd1, 1'b1, 3, 0, 0, 0);
    chk("abort_start_idle", cw | cv | cb | cd, 32'b0);

    tx(8'h0B, 4'd4, 4'd1, 1'b0, 6, 0, 2, 1);
    chk("restart_w", cw, 32'b101100);
    chk("restart_busy", cb, 32'b111100);
    chk("restart_done", cd, 32'b000010);
    tx(8'h0B, 4'd4, 4'd1, 1'b0, 2, 0, 0, 0);
    chk("after_done_restart", cw, 32'b10);
    do_rst();

    tx(8'hA5, 4'd8, 4'd1, 1'b0, 6, 0, 3, 2);
    chk("rst_w", cw, 32'b101000);
    chk("rst_busy", cb, 32'b111000);
    chk("rst_done", cd, 32'b0);
    tx(8'hA5, 4'd8, 4'd1, 1'b0, 10, 0, 0, 0);
    chk("post_rst_w", cw, 32'b1010010100);
    chk("post_rst_busy", cb, 32'b1111111100);
    chk("post_rst_done", cd, 32'b0000000010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
